// File: rtl/al_arbiter_2to1.sv
// rtl/al_arbiter_2to1.sv - two-master round-robin AL arbiter with read-response timeout
//
// Purpose:
//   Serializes single-beat AL transactions from two masters onto one AL slave
//   port. Master 0 is the PCIe completer bridge, master 1 a local on-chip
//   master. A read that gets no slave response within TIMEOUT cycles is
//   completed towards the master with TIMEOUT_DATA, so host MMIO reads cannot
//   hang on a dead slave.
//
// Ports:
//   user_clk, user_reset      clock, synchronous active-high reset
//   sN_al_waddr/wdata/wvalid  write channel from master N (in), sN_al_wready (out)
//   sN_al_araddr/arvalid      read-address channel from master N (in), sN_al_arready (out)
//   sN_al_rdata/rvalid        read-data channel to master N (out), sN_al_rready (in)
//   m_al_waddr/wdata/wvalid   write channel to the slave (out), m_al_wready (in)
//   m_al_araddr/arvalid       read-address channel to the slave (out), m_al_arready (in)
//   m_al_rdata/rvalid         read-data channel from the slave (in), m_al_rready (out)
//   grant_id                  master currently or last granted
//   busy                      arbiter is not idle
//   timeout_flag              sticky: a read timeout has occurred since reset

module al_arbiter_2to1 #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned TIMEOUT      = 1024,
    parameter logic [31:0] TIMEOUT_DATA = 32'hFFFF_FFFF
) (
    input  logic                  user_clk,
    input  logic                  user_reset,

    input  logic [ADDR_WIDTH-1:2] s0_al_waddr,
    input  logic [31:0]           s0_al_wdata,
    input  logic                  s0_al_wvalid,
    output logic                  s0_al_wready,
    input  logic [ADDR_WIDTH-1:2] s0_al_araddr,
    input  logic                  s0_al_arvalid,
    output logic                  s0_al_arready,
    output logic [31:0]           s0_al_rdata,
    output logic                  s0_al_rvalid,
    input  logic                  s0_al_rready,

    input  logic [ADDR_WIDTH-1:2] s1_al_waddr,
    input  logic [31:0]           s1_al_wdata,
    input  logic                  s1_al_wvalid,
    output logic                  s1_al_wready,
    input  logic [ADDR_WIDTH-1:2] s1_al_araddr,
    input  logic                  s1_al_arvalid,
    output logic                  s1_al_arready,
    output logic [31:0]           s1_al_rdata,
    output logic                  s1_al_rvalid,
    input  logic                  s1_al_rready,

    output logic [ADDR_WIDTH-1:2] m_al_waddr,
    output logic [31:0]           m_al_wdata,
    output logic                  m_al_wvalid,
    input  logic                  m_al_wready,
    output logic [ADDR_WIDTH-1:2] m_al_araddr,
    output logic                  m_al_arvalid,
    input  logic                  m_al_arready,
    input  logic [31:0]           m_al_rdata,
    input  logic                  m_al_rvalid,
    output logic                  m_al_rready,

    output logic                  grant_id,
    output logic                  busy,
    output logic                  timeout_flag
);

    // Counter only needs to reach TIMEOUT-1; it saturates there.
    localparam int unsigned     CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_RD_ERR
    } state_t;

    state_t           state_q, state_d;
    logic             grant_q, grant_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic             stale_q, stale_d;
    logic             timeout_flag_q, timeout_flag_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Requests: a read is not eligible while a timed-out response is still
    // outstanding on the slave, otherwise the late data would be delivered
    // to the wrong transaction.
    logic req0, req1, pick, pick_wvalid;

    // Payload/handshake of the currently granted master.
    logic                  sel_wvalid, sel_arvalid, sel_rready;
    logic [ADDR_WIDTH-1:2] sel_waddr, sel_araddr;
    logic [31:0]           sel_wdata;

    logic timeout_hit;

    assign req0 = s0_al_wvalid | (s0_al_arvalid & ~stale_q);
    assign req1 = s1_al_wvalid | (s1_al_arvalid & ~stale_q);

    // Contention is settled by rr_ptr; otherwise the lone requester wins.
    assign pick        = (req0 & req1) ? rr_ptr_q : req1;
    assign pick_wvalid = pick ? s1_al_wvalid : s0_al_wvalid;

    assign sel_wvalid  = grant_q ? s1_al_wvalid  : s0_al_wvalid;
    assign sel_waddr   = grant_q ? s1_al_waddr   : s0_al_waddr;
    assign sel_wdata   = grant_q ? s1_al_wdata   : s0_al_wdata;
    assign sel_arvalid = grant_q ? s1_al_arvalid : s0_al_arvalid;
    assign sel_araddr  = grant_q ? s1_al_araddr  : s0_al_araddr;
    assign sel_rready  = grant_q ? s1_al_rready  : s0_al_rready;

    // A slave rvalid in the expiry cycle takes the normal path.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST) && !m_al_rvalid;

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            state_q        <= ST_IDLE;
            grant_q        <= 1'b0;
            rr_ptr_q       <= 1'b0;
            stale_q        <= 1'b0;
            timeout_flag_q <= 1'b0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            rr_ptr_q       <= rr_ptr_d;
            stale_q        <= stale_d;
            timeout_flag_q <= timeout_flag_d;
            cnt_q          <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        rr_ptr_d       = rr_ptr_q;
        stale_d        = stale_q;
        timeout_flag_d = timeout_flag_q;
        cnt_d          = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (req0 | req1) begin
                    grant_d  = pick;
                    rr_ptr_d = ~pick;
                    // A master presenting both channels gets its write first.
                    state_d  = pick_wvalid ? ST_WR : ST_RD_ADDR;
                end
            end
            ST_WR: begin
                if (sel_wvalid && m_al_wready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_ADDR: begin
                if (sel_arvalid && m_al_arready) begin
                    state_d = ST_RD_DATA;
                    cnt_d   = '0;
                end
            end
            ST_RD_DATA: begin
                if (m_al_rvalid && sel_rready) begin
                    state_d = ST_IDLE;
                end else if (timeout_hit) begin
                    state_d        = ST_RD_ERR;
                    stale_d        = 1'b1;
                    timeout_flag_d = 1'b1;
                end else if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RD_ERR: begin
                if (sel_rready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The late response of a timed-out read is swallowed here; stale can
        // never be set while in RD_DATA, so this cannot race the set above.
        if (stale_q && (state_q != ST_RD_DATA) && m_al_rvalid) begin
            stale_d = 1'b0;
        end
    end

    always_comb begin
        m_al_waddr    = '0;
        m_al_wdata    = '0;
        m_al_wvalid   = 1'b0;
        m_al_araddr   = '0;
        m_al_arvalid  = 1'b0;
        m_al_rready   = 1'b0;
        s0_al_wready  = 1'b0;
        s0_al_arready = 1'b0;
        s0_al_rdata   = '0;
        s0_al_rvalid  = 1'b0;
        s1_al_wready  = 1'b0;
        s1_al_arready = 1'b0;
        s1_al_rdata   = '0;
        s1_al_rvalid  = 1'b0;

        case (state_q)
            ST_WR: begin
                m_al_waddr  = sel_waddr;
                m_al_wdata  = sel_wdata;
                m_al_wvalid = sel_wvalid;
                if (grant_q) s1_al_wready = m_al_wready;
                else         s0_al_wready = m_al_wready;
            end
            ST_RD_ADDR: begin
                m_al_araddr  = sel_araddr;
                m_al_arvalid = sel_arvalid;
                if (grant_q) s1_al_arready = m_al_arready;
                else         s0_al_arready = m_al_arready;
            end
            ST_RD_DATA: begin
                m_al_rready = sel_rready;
                if (grant_q) begin
                    s1_al_rdata  = m_al_rdata;
                    s1_al_rvalid = m_al_rvalid;
                end else begin
                    s0_al_rdata  = m_al_rdata;
                    s0_al_rvalid = m_al_rvalid;
                end
            end
            ST_RD_ERR: begin
                if (grant_q) begin
                    s1_al_rdata  = TIMEOUT_DATA;
                    s1_al_rvalid = 1'b1;
                end else begin
                    s0_al_rdata  = TIMEOUT_DATA;
                    s0_al_rvalid = 1'b1;
                end
            end
            default: begin
            end
        endcase

        // Outside RD_DATA the slave read channel belongs to the drain logic.
        if (stale_q && (state_q != ST_RD_DATA)) begin
            m_al_rready = 1'b1;
        end
    end

    assign grant_id     = grant_q;
    assign busy         = (state_q != ST_IDLE);
    assign timeout_flag = timeout_flag_q;

endmodule

// File: tb/tb_al_arbiter_2to1.sv
// tb/tb_al_arbiter_2to1.sv - scoreboard bench for al_arbiter_2to1
module tb_al_arbiter_2to1;

    localparam int AW = 30;

    logic          user_clk = 1'b0;
    logic          user_reset;
    logic [AW-1:0] s0_al_waddr, s1_al_waddr, s0_al_araddr, s1_al_araddr;
    logic [31:0]   s0_al_wdata, s1_al_wdata;
    logic          s0_al_wvalid, s1_al_wvalid, s0_al_arvalid, s1_al_arvalid;
    logic          s0_al_rready, s1_al_rready;
    logic          s0_al_wready, s1_al_wready, s0_al_arready, s1_al_arready;
    logic [31:0]   s0_al_rdata, s1_al_rdata;
    logic          s0_al_rvalid, s1_al_rvalid;
    logic [AW-1:0] m_al_waddr, m_al_araddr;
    logic [31:0]   m_al_wdata, m_al_rdata;
    logic          m_al_wvalid, m_al_wready, m_al_arvalid, m_al_arready;
    logic          m_al_rvalid, m_al_rready;
    logic          grant_id, busy, timeout_flag;

    al_arbiter_2to1 #(.ADDR_WIDTH(32), .TIMEOUT(16), .TIMEOUT_DATA(32'hFFFF_FFFF)) dut (
        .user_clk(user_clk), .user_reset(user_reset),
        .s0_al_waddr(s0_al_waddr), .s0_al_wdata(s0_al_wdata), .s0_al_wvalid(s0_al_wvalid),
        .s0_al_wready(s0_al_wready), .s0_al_araddr(s0_al_araddr), .s0_al_arvalid(s0_al_arvalid),
        .s0_al_arready(s0_al_arready), .s0_al_rdata(s0_al_rdata), .s0_al_rvalid(s0_al_rvalid),
        .s0_al_rready(s0_al_rready),
        .s1_al_waddr(s1_al_waddr), .s1_al_wdata(s1_al_wdata), .s1_al_wvalid(s1_al_wvalid),
        .s1_al_wready(s1_al_wready), .s1_al_araddr(s1_al_araddr), .s1_al_arvalid(s1_al_arvalid),
        .s1_al_arready(s1_al_arready), .s1_al_rdata(s1_al_rdata), .s1_al_rvalid(s1_al_rvalid),
        .s1_al_rready(s1_al_rready),
        .m_al_waddr(m_al_waddr), .m_al_wdata(m_al_wdata), .m_al_wvalid(m_al_wvalid),
        .m_al_wready(m_al_wready), .m_al_araddr(m_al_araddr), .m_al_arvalid(m_al_arvalid),
        .m_al_arready(m_al_arready), .m_al_rdata(m_al_rdata), .m_al_rvalid(m_al_rvalid),
        .m_al_rready(m_al_rready),
        .grant_id(grant_id), .busy(busy), .timeout_flag(timeout_flag)
    );

    always #5 user_clk = ~user_clk;

    typedef struct { logic m; logic [AW-1:0] a; logic [31:0] d; } wr_t;
    typedef struct { logic m; logic [31:0] d; } rd_t;

    wr_t exp_wr[$];
    rd_t exp_rd[$];
    int  wr_cyc[$];
    int  cyc = 0;
    int  n_vec = 0;
    int  n_err = 0;

    always @(posedge user_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expired(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: wait expired (t=%0t)", name, $time);
    endtask

    task automatic step();
        @(posedge user_clk);
        #1;
    endtask

    function automatic logic [11:0] ctl_vec();
        return {busy, grant_id, timeout_flag, m_al_wvalid, m_al_arvalid, m_al_rready,
                s0_al_wready, s0_al_arready, s0_al_rvalid,
                s1_al_wready, s1_al_arready, s1_al_rvalid};
    endfunction

    // Scoreboard monitor: pops an expectation whenever a transfer completes.
    always @(negedge user_clk) begin
        if (!user_reset) begin
            if (m_al_wvalid && m_al_wready) begin
                wr_cyc.push_back(cyc);
                if (exp_wr.size() == 0) begin
                    expired("unexpected_write");
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("wr_grant", grant_id, e.m);
                    chk("wr_addr", m_al_waddr, e.a);
                    chk("wr_data", m_al_wdata, e.d);
                    chk("wr_ready_route", {s1_al_wready, s0_al_wready}, e.m ? 2'b10 : 2'b01);
                end
            end
            if (s0_al_rvalid && s0_al_rready) begin
                if (exp_rd.size() == 0) expired("unexpected_read_s0");
                else begin
                    rd_t e;
                    e = exp_rd.pop_front();
                    chk("rd_master_s0", 1'b0, e.m);
                    chk("rd_data_s0", s0_al_rdata, e.d);
                    chk("rd_other_s1", {s1_al_rvalid, s1_al_rdata}, 33'h0);
                end
            end
            if (s1_al_rvalid && s1_al_rready) begin
                if (exp_rd.size() == 0) expired("unexpected_read_s1");
                else begin
                    rd_t e;
                    e = exp_rd.pop_front();
                    chk("rd_master_s1", 1'b1, e.m);
                    chk("rd_data_s1", s1_al_rdata, e.d);
                    chk("rd_other_s0", {s0_al_rvalid, s0_al_rdata}, 33'h0);
                end
            end
        end
    end

    // Master write: called at posedge+1, returns at posedge+1 after the handshake.
    task automatic mwrite(input int m, input logic [AW-1:0] a, input logic [31:0] d);
        bit done = 0;
        if (m == 0) begin s0_al_waddr = a; s0_al_wdata = d; s0_al_wvalid = 1'b1; end
        else        begin s1_al_waddr = a; s1_al_wdata = d; s1_al_wvalid = 1'b1; end
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge user_clk);
            if ((m == 0) ? s0_al_wready : s1_al_wready) done = 1;
        end
        if (!done) expired("mwrite_wready");
        step();
        if (m == 0) s0_al_wvalid = 1'b0;
        else        s1_al_wvalid = 1'b0;
    endtask

    task automatic mread(input int m, input logic [AW-1:0] a);
        bit done = 0;
        if (m == 0) begin s0_al_araddr = a; s0_al_arvalid = 1'b1; s0_al_rready = 1'b1; end
        else        begin s1_al_araddr = a; s1_al_arvalid = 1'b1; s1_al_rready = 1'b1; end
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge user_clk);
            if ((m == 0) ? s0_al_arready : s1_al_arready) done = 1;
        end
        if (!done) expired("mread_arready");
        step();
        if (m == 0) s0_al_arvalid = 1'b0;
        else        s1_al_arvalid = 1'b0;
        done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge user_clk);
            if ((m == 0) ? s0_al_rvalid : s1_al_rvalid) done = 1;
        end
        if (!done) expired("mread_rvalid");
        step();
        if (m == 0) s0_al_rready = 1'b0;
        else        s1_al_rready = 1'b0;
    endtask

    // Slave read responder: rvalid lat cycles after the address handshake.
    task automatic slave_rd(input int lat, input logic [31:0] d);
        bit done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge user_clk);
            if (m_al_arvalid && m_al_arready) done = 1;
        end
        if (!done) expired("slave_ar");
        repeat (lat) @(posedge user_clk);
        #1;
        m_al_rvalid = 1'b1;
        m_al_rdata  = d;
        done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge user_clk);
            if (m_al_rready) done = 1;
        end
        if (!done) expired("slave_rready");
        step();
        m_al_rvalid = 1'b0;
        m_al_rdata  = '0;
    endtask

    task automatic wait_ar_hs(input string name);
        bit done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge user_clk);
            if (m_al_arvalid && m_al_arready) done = 1;
        end
        if (!done) expired(name);
    endtask

    initial begin
        user_reset = 1'b1;
        s0_al_waddr = '0; s0_al_wdata = '0; s0_al_wvalid = 0; s0_al_araddr = '0;
        s0_al_arvalid = 0; s0_al_rready = 0;
        s1_al_waddr = '0; s1_al_wdata = '0; s1_al_wvalid = 0; s1_al_araddr = '0;
        s1_al_arvalid = 0; s1_al_rready = 0;
        m_al_wready = 1'b1; m_al_arready = 1'b1; m_al_rvalid = 1'b0; m_al_rdata = '0;
        repeat (3) step();
        user_reset = 1'b0;
        @(negedge user_clk);
        chk("reset_ctl", ctl_vec(), 12'h0);
        chk("reset_rdata", {s0_al_rdata, s1_al_rdata}, 64'h0);

        // Single write from master 1, timing checked cycle by cycle.
        step();
        s1_al_waddr = 30'h4; s1_al_wdata = 32'hA5A5_0001; s1_al_wvalid = 1'b1;
        exp_wr.push_back('{1'b1, 30'h4, 32'hA5A5_0001});
        @(negedge user_clk);
        chk("t1_no_valid_at_T", {busy, m_al_wvalid}, 2'b00);
        @(negedge user_clk);
        chk("t1_valid_at_T1", {m_al_wvalid, s1_al_wready, s0_al_wready, grant_id}, 4'b1101);
        step();
        s1_al_wvalid = 1'b0;
        @(negedge user_clk);
        chk("t1_idle_at_T2", busy, 1'b0);

        // Both masters write back-to-back: grants alternate every 2 cycles.
        step();
        for (int i = 0; i < 4; i++) begin
            exp_wr.push_back('{1'b0, AW'(32'h40 + i), 32'hB000_0000 | i});
            exp_wr.push_back('{1'b1, AW'(32'h50 + i), 32'hB000_0100 | i});
        end
        wr_cyc.delete();
        fork
            for (int i = 0; i < 4; i++) mwrite(0, AW'(32'h40 + i), 32'hB000_0000 | i);
            for (int i = 0; i < 4; i++) mwrite(1, AW'(32'h50 + i), 32'hB000_0100 | i);
        join
        chk("t2_count", wr_cyc.size(), 8);
        for (int i = 1; i < wr_cyc.size(); i++) chk("t2_period", wr_cyc[i] - wr_cyc[i-1], 2);

        // Normal read from master 0 with 5-cycle slave latency.
        exp_rd.push_back('{1'b0, 32'h1234_5678});
        fork
            mread(0, 30'h8);
            slave_rd(5, 32'h1234_5678);
        join
        @(negedge user_clk);
        chk("t3_flag", {timeout_flag, busy}, 2'b00);

        // rvalid lands in the expiry cycle: real data, no timeout.
        step();
        s0_al_araddr = 30'hC; s0_al_arvalid = 1'b1; s0_al_rready = 1'b1;
        exp_rd.push_back('{1'b0, 32'h5A5A_0015});
        wait_ar_hs("t5_ar");
        step();
        s0_al_arvalid = 1'b0;
        repeat (15) step();
        m_al_rvalid = 1'b1; m_al_rdata = 32'h5A5A_0015;
        @(negedge user_clk);
        chk("t5_rvalid", s0_al_rvalid, 1'b1);
        step();
        m_al_rvalid = 1'b0; m_al_rdata = '0; s0_al_rready = 1'b0;
        @(negedge user_clk);
        chk("t5_after", {timeout_flag, busy}, 2'b00);

        // Timeout: slave never answers master 0.
        step();
        s0_al_araddr = 30'h10; s0_al_arvalid = 1'b1; s0_al_rready = 1'b0;
        exp_rd.push_back('{1'b0, 32'hFFFF_FFFF});
        wait_ar_hs("t4_ar");
        step();
        s0_al_arvalid = 1'b0;
        repeat (15) @(negedge user_clk);
        @(negedge user_clk);
        chk("t4_before_expiry", {s0_al_rvalid, timeout_flag}, 2'b00);
        @(negedge user_clk);
        chk("t4_err_rvalid", {s0_al_rvalid, timeout_flag, m_al_rready}, 3'b111);
        chk("t4_err_rdata", s0_al_rdata, 32'hFFFF_FFFF);
        step();
        s0_al_rready = 1'b1;
        @(negedge user_clk);
        step();
        s0_al_rready = 1'b0;
        // Master 1 read is withheld while the late response is pending.
        s1_al_araddr = 30'h14; s1_al_arvalid = 1'b1;
        repeat (3) @(negedge user_clk);
        chk("t4_read_withheld", {busy, m_al_arvalid, m_al_rready, s1_al_arready}, 4'b0010);
        step();
        exp_wr.push_back('{1'b1, 30'h18, 32'h7777_0001});
        mwrite(1, 30'h18, 32'h7777_0001);
        @(negedge user_clk);
        chk("t4_still_withheld", {busy, m_al_arvalid}, 2'b00);
        step();
        m_al_rvalid = 1'b1; m_al_rdata = 32'hDEAD_BEEF;
        @(negedge user_clk);
        chk("t4_late_absorbed", {m_al_rready, s0_al_rvalid, s1_al_rvalid}, 3'b100);
        step();
        m_al_rvalid = 1'b0; m_al_rdata = '0;
        exp_rd.push_back('{1'b1, 32'hCAFE_0001});
        fork
            mread(1, 30'h14);
            slave_rd(3, 32'hCAFE_0001);
        join
        @(negedge user_clk);
        chk("t4_flag_sticky", {timeout_flag, m_al_rready}, 2'b10);

        // Reset in RD_DATA abandons the read.
        step();
        s0_al_araddr = 30'h1C; s0_al_arvalid = 1'b1; s0_al_rready = 1'b0;
        wait_ar_hs("t6_ar");
        step();
        s0_al_arvalid = 1'b0;
        step();
        user_reset = 1'b1;
        @(negedge user_clk);
        @(negedge user_clk);
        chk("t6_reset_ctl", ctl_vec(), 12'h0);
        chk("t6_reset_rdata", {s0_al_rdata, s1_al_rdata}, 64'h0);
        step();
        user_reset = 1'b0;
        exp_wr.push_back('{1'b0, 30'h20, 32'h6666_0001});
        mwrite(0, 30'h20, 32'h6666_0001);
        @(negedge user_clk);
        chk("t6_idle", busy, 1'b0);

        chk("sb_wr_drained", exp_wr.size(), 0);
        chk("sb_rd_drained", exp_rd.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
